decode: RTL and testbench

Second stage of the RV32I multicycle pipeline, directly downstream of instruction fetch. It accepts a fetched instruction word and its PC pair over the ready/send handshake, then decodes the word into operation class, ALU operation, register indices and sign-extended immediate. It reads both source operands from the register file and holds the decoded bundle until the execute stage accepts it. Start and interrupt pulses flush any held instruction.

---
 rtl/rv32_pkg.sv | 80 ++++++++
 rtl/decode_imm_gen.sv | 45 ++++
 rtl/decode.sv | 194 +++++++++++++++++++
 tb/tb_decode.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, operation classes, ALU codes, FSM states.
// Latency: none (definitions only).
// Backpressure: not applicable.
package rv32_pkg;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        OT_LUI    = 4'd0,
        OT_AUIPC  = 4'd1,
        OT_JAL    = 4'd2,
        OT_JALR   = 4'd3,
        OT_BRANCH = 4'd4,
        OT_LOAD   = 4'd5,
        OT_STORE  = 4'd6,
        OT_OPIMM  = 4'd7,
        OT_OP     = 4'd8,
        OT_FENCE  = 4'd9,
        OT_SYSTEM = 4'd10
    } op_type_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_BEF = 2'd1,
        ST_HOLD     = 2'd2
    } state_e;

    // Immediate layout; FMT_R marks register-register ops, FMT_NONE an unknown opcode
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6
    } imm_fmt_e;

    // ALU op for OP/OPIMM; instr[30] selects SUB only for register-register ops
    function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic b30,
                                                input logic is_op);
        alu_op_e op;
        case (f3)
            3'b000:  op = (is_op && b30) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = b30 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Immediate generator: instruction word to sign-extended immediate and its format.
// Latency: combinational.
// Backpressure: none; pure function of the instruction word.
module decode_imm_gen
    import rv32_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [31:0] o_imm,
    output imm_fmt_e    o_fmt
);

    logic       w_sign;
    assign w_sign = i_instr[31];

    // Pick the immediate layout from the opcode
    always_comb begin
        o_fmt = FMT_NONE;
        case (i_instr[6:0])
            OPC_LUI, OPC_AUIPC:                        o_fmt = FMT_U;
            OPC_JAL:                                   o_fmt = FMT_J;
            OPC_JALR, OPC_LOAD, OPC_OPIMM,
            OPC_FENCE, OPC_SYSTEM:                     o_fmt = FMT_I;
            OPC_BRANCH:                                o_fmt = FMT_B;
            OPC_STORE:                                 o_fmt = FMT_S;
            OPC_OP:                                    o_fmt = FMT_R;
            default:                                   o_fmt = FMT_NONE;
        endcase
    end

    // Assemble and sign-extend the immediate for the chosen layout
    always_comb begin
        o_imm = 32'd0;
        case (o_fmt)
            FMT_I: o_imm = {{20{w_sign}}, i_instr[31:20]};
            FMT_S: o_imm = {{20{w_sign}}, i_instr[31:25], i_instr[11:7]};
            FMT_B: o_imm = {{19{w_sign}}, i_instr[31], i_instr[7], i_instr[30:25],
                            i_instr[11:8], 1'b0};
            FMT_U: o_imm = {i_instr[31:12], 12'd0};
            FMT_J: o_imm = {{11{w_sign}}, i_instr[31], i_instr[19:12], i_instr[20],
                            i_instr[30:21], 1'b0};
            default: o_imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: registers the decoded bundle plus operands read from the register file.
// Latency: 1 cycle from accepted instruction to curPipReadyToSend.
// Backpressure: bundle held while execute stalls; a new word is taken in the same cycle the held one leaves.
module decode
    import rv32_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int READ_ADDR_SIZE = 32,
    parameter int REG_IDX        = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      startSig,
    input  logic                      interrupt_start,
    input  logic [XLEN-1:0]           fetch_data,
    input  logic [READ_ADDR_SIZE-1:0] fetch_cur_pc,
    input  logic [READ_ADDR_SIZE-1:0] fetch_nxt_pc,
    input  logic                      beforePipReadyToSend,
    input  logic                      nextPipReadyToRcv,
    output logic [REG_IDX-1:0]        rf_rs1_addr,
    output logic [REG_IDX-1:0]        rf_rs2_addr,
    input  logic [XLEN-1:0]           rf_rs1_data,
    input  logic [XLEN-1:0]           rf_rs2_data,
    output logic [XLEN-1:0]           dec_rs1_val,
    output logic [XLEN-1:0]           dec_rs2_val,
    output logic [XLEN-1:0]           dec_imm,
    output logic [REG_IDX-1:0]        dec_rd,
    output logic [3:0]                dec_opType,
    output logic [3:0]                dec_aluOp,
    output logic [2:0]                dec_funct3,
    output logic                      dec_illegal,
    output logic [READ_ADDR_SIZE-1:0] dec_cur_pc,
    output logic [READ_ADDR_SIZE-1:0] dec_nxt_pc,
    output logic                      curPipReadyToRcv,
    output logic                      curPipReadyToSend
);

    state_e                    r_state;
    logic [XLEN-1:0]           r_rs1_val;
    logic [XLEN-1:0]           r_rs2_val;
    logic [XLEN-1:0]           r_imm;
    logic [REG_IDX-1:0]        r_rd;
    op_type_e                  r_opType;
    alu_op_e                   r_aluOp;
    logic [2:0]                r_funct3;
    logic                      r_illegal;
    logic [READ_ADDR_SIZE-1:0] r_cur_pc;
    logic [READ_ADDR_SIZE-1:0] r_nxt_pc;

    logic       w_flush;
    logic       w_xfer_in;
    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic [31:0] w_imm;
    imm_fmt_e   w_fmt;
    op_type_e   w_opType;
    alu_op_e    w_aluOp;
    logic       w_illegal;
    logic       w_wb;
    logic [REG_IDX-1:0] w_rd;
    logic [XLEN-1:0]    w_rs1_val;
    logic [XLEN-1:0]    w_rs2_val;

    assign w_flush = startSig | interrupt_start;
    assign w_opc   = fetch_data[6:0];
    assign w_f3    = fetch_data[14:12];
    assign w_f7    = fetch_data[31:25];

    // A flush cycle never accepts; the held slot frees up in the cycle execute takes it
    assign curPipReadyToRcv  = ((r_state == ST_WAIT_BEF) |
                                ((r_state == ST_HOLD) & nextPipReadyToRcv)) & ~w_flush;
    assign curPipReadyToSend = (r_state == ST_HOLD);
    assign w_xfer_in         = curPipReadyToRcv & beforePipReadyToSend;

    assign rf_rs1_addr = fetch_data[19:15];
    assign rf_rs2_addr = fetch_data[24:20];

    // x0 always reads as zero whatever the register file returns
    assign w_rs1_val = (rf_rs1_addr == '0) ? '0 : rf_rs1_data;
    assign w_rs2_val = (rf_rs2_addr == '0) ? '0 : rf_rs2_data;

    decode_imm_gen u_imm_gen (
        .i_instr (fetch_data[31:0]),
        .o_imm   (w_imm),
        .o_fmt   (w_fmt)
    );

    // Classify the word: operation class, ALU op, writeback and legality
    always_comb begin
        w_opType  = OT_LUI;
        w_aluOp   = ALU_ADD;
        w_wb      = 1'b0;
        w_illegal = (w_fmt == FMT_NONE);
        case (w_opc)
            OPC_LUI:    begin w_opType = OT_LUI;   w_wb = 1'b1; end
            OPC_AUIPC:  begin w_opType = OT_AUIPC; w_wb = 1'b1; end
            OPC_JAL:    begin w_opType = OT_JAL;   w_wb = 1'b1; end
            OPC_JALR: begin
                w_opType  = OT_JALR;
                w_wb      = 1'b1;
                w_illegal = (w_f3 != 3'b000);
            end
            OPC_BRANCH: begin
                w_opType  = OT_BRANCH;
                w_aluOp   = ALU_SUB;
                w_illegal = (w_f3 == 3'b010) | (w_f3 == 3'b011);
            end
            OPC_LOAD: begin
                w_opType  = OT_LOAD;
                w_wb      = 1'b1;
                w_illegal = (w_f3 == 3'b011) | (w_f3 == 3'b110) | (w_f3 == 3'b111);
            end
            OPC_STORE: begin
                w_opType  = OT_STORE;
                w_illegal = (w_f3 > 3'b010);
            end
            OPC_OPIMM: begin
                w_opType  = OT_OPIMM;
                w_wb      = 1'b1;
                w_aluOp   = alu_from_funct3(w_f3, fetch_data[30], 1'b0);
                // Shift-immediates carry funct7 in the immediate field
                w_illegal = ((w_f3 == 3'b001) & (w_f7 != 7'h00)) |
                            ((w_f3 == 3'b101) & (w_f7 != 7'h00) & (w_f7 != 7'h20));
            end
            OPC_OP: begin
                w_opType  = OT_OP;
                w_wb      = 1'b1;
                w_aluOp   = alu_from_funct3(w_f3, fetch_data[30], 1'b1);
                w_illegal = ~((w_f7 == 7'h00) |
                              ((w_f7 == 7'h20) & ((w_f3 == 3'b000) | (w_f3 == 3'b101))));
            end
            OPC_FENCE:  w_opType = OT_FENCE;
            OPC_SYSTEM: w_opType = OT_SYSTEM;
            default: ;
        endcase
    end

    // Illegal words flow downstream but must never write a register
    assign w_rd = (w_wb & ~w_illegal) ? fetch_data[11:7] : '0;

    // Handshake FSM and decoded-bundle register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_rs1_val <= '0;
            r_rs2_val <= '0;
            r_imm     <= '0;
            r_rd      <= '0;
            r_opType  <= OT_LUI;
            r_aluOp   <= ALU_ADD;
            r_funct3  <= '0;
            r_illegal <= 1'b0;
            r_cur_pc  <= '0;
            r_nxt_pc  <= '0;
        end else if (w_flush) begin
            r_state <= ST_WAIT_BEF;
        end else begin
            case (r_state)
                ST_IDLE:     r_state <= ST_IDLE;
                ST_WAIT_BEF: if (w_xfer_in) r_state <= ST_HOLD;
                ST_HOLD: begin
                    if (w_xfer_in)             r_state <= ST_HOLD;
                    else if (nextPipReadyToRcv) r_state <= ST_WAIT_BEF;
                end
                default:     r_state <= ST_IDLE;
            endcase
            if (w_xfer_in) begin
                r_rs1_val <= w_rs1_val;
                r_rs2_val <= w_rs2_val;
                r_imm     <= w_imm;
                r_rd      <= w_rd;
                r_opType  <= w_opType;
                r_aluOp   <= w_aluOp;
                r_funct3  <= w_f3;
                r_illegal <= w_illegal;
                r_cur_pc  <= fetch_cur_pc;
                r_nxt_pc  <= fetch_nxt_pc;
            end
        end
    end

    assign dec_rs1_val = r_rs1_val;
    assign dec_rs2_val = r_rs2_val;
    assign dec_imm     = r_imm;
    assign dec_rd      = r_rd;
    assign dec_opType  = r_opType;
    assign dec_aluOp   = r_aluOp;
    assign dec_funct3  = r_funct3;
    assign dec_illegal = r_illegal;
    assign dec_cur_pc  = r_cur_pc;
    assign dec_nxt_pc  = r_nxt_pc;

endmodule

// File: tb/tb_decode.sv
// Bench for decode: directed scenarios followed by random traffic against a behavioural model.
// Latency: checks registered outputs 1 ns after each rising edge.
// Backpressure: random execute stalls, fetch gaps and flush pulses.
module tb_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        startSig, interrupt_start;
    logic [31:0] fetch_data, fetch_cur_pc, fetch_nxt_pc;
    logic        beforePipReadyToSend, nextPipReadyToRcv;
    logic [4:0]  rf_rs1_addr, rf_rs2_addr;
    logic [31:0] rf_rs1_data, rf_rs2_data;
    logic [31:0] dec_rs1_val, dec_rs2_val, dec_imm;
    logic [4:0]  dec_rd;
    logic [3:0]  dec_opType, dec_aluOp;
    logic [2:0]  dec_funct3;
    logic        dec_illegal;
    logic [31:0] dec_cur_pc, dec_nxt_pc;
    logic        curPipReadyToRcv, curPipReadyToSend;

    logic [31:0] rf_mem [32];
    assign rf_rs1_data = rf_mem[rf_rs1_addr];
    assign rf_rs2_data = rf_mem[rf_rs2_addr];

    always #5 clk = ~clk;

    decode dut (
        .clk(clk), .rst(rst), .startSig(startSig), .interrupt_start(interrupt_start),
        .fetch_data(fetch_data), .fetch_cur_pc(fetch_cur_pc), .fetch_nxt_pc(fetch_nxt_pc),
        .beforePipReadyToSend(beforePipReadyToSend), .nextPipReadyToRcv(nextPipReadyToRcv),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .dec_rs1_val(dec_rs1_val), .dec_rs2_val(dec_rs2_val), .dec_imm(dec_imm),
        .dec_rd(dec_rd), .dec_opType(dec_opType), .dec_aluOp(dec_aluOp),
        .dec_funct3(dec_funct3), .dec_illegal(dec_illegal),
        .dec_cur_pc(dec_cur_pc), .dec_nxt_pc(dec_nxt_pc),
        .curPipReadyToRcv(curPipReadyToRcv), .curPipReadyToSend(curPipReadyToSend)
    );

    typedef struct {
        logic [31:0] rs1, rs2, imm, cur, nxt;
        int          rd, typ, alu, f3;
        bit          ill, known;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    bit   m_idle, m_has;
    exp_t m_b;
    logic [31:0] pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int alu_of(input int f3, input bit b30, input bit is_op);
        case (f3)
            0: return (is_op && b30) ? 1 : 0;
            1: return 2;
            2: return 3;
            3: return 4;
            4: return 5;
            5: return b30 ? 7 : 6;
            6: return 8;
            default: return 9;
        endcase
    endfunction

    // Behavioural decode written from the ISA rules with integer arithmetic
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] r1,
                                        input logic [31:0] r2, input logic [31:0] cp,
                                        input logic [31:0] np);
        exp_t e;
        int op, f3, f7, i_imm, s_imm, b_imm, j_imm;
        bit wb;
        op    = int'(w[6:0]);
        f3    = int'(w[14:12]);
        f7    = int'(w[31:25]);
        i_imm = $signed(w) >>> 20;
        s_imm = ($signed(w) >>> 25) * 32 + int'(w[11:7]);
        b_imm = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        j_imm = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
              + int'(w[30:21]) * 2;
        e.rs1 = (w[19:15] == 5'd0) ? 32'd0 : r1;
        e.rs2 = (w[24:20] == 5'd0) ? 32'd0 : r2;
        e.f3 = f3; e.cur = cp; e.nxt = np;
        e.known = 1'b1; e.ill = 1'b0; e.alu = 0; e.imm = 32'd0; e.typ = 0;
        wb = 1'b0;
        case (op)
            'h37: begin e.typ = 0; e.imm = w & 32'hFFFFF000; wb = 1; end
            'h17: begin e.typ = 1; e.imm = w & 32'hFFFFF000; wb = 1; end
            'h6F: begin e.typ = 2; e.imm = 32'(j_imm); wb = 1; end
            'h67: begin e.typ = 3; e.imm = 32'(i_imm); wb = 1; e.ill = (f3 != 0); end
            'h63: begin e.typ = 4; e.imm = 32'(b_imm); e.alu = 1; e.ill = (f3 == 2 || f3 == 3); end
            'h03: begin e.typ = 5; e.imm = 32'(i_imm); wb = 1; e.ill = (f3 == 3 || f3 >= 6); end
            'h23: begin e.typ = 6; e.imm = 32'(s_imm); e.ill = (f3 > 2); end
            'h13: begin
                e.typ = 7; e.imm = 32'(i_imm); wb = 1; e.alu = alu_of(f3, w[30], 0);
                e.ill = (f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 'h20);
            end
            'h33: begin
                e.typ = 8; wb = 1; e.alu = alu_of(f3, w[30], 1);
                e.ill = !(f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5)));
            end
            'h0F: begin e.typ = 9;  e.imm = 32'(i_imm); end
            'h73: begin e.typ = 10; e.imm = 32'(i_imm); end
            default: begin e.known = 1'b0; e.ill = 1'b1; end
        endcase
        e.rd = (wb && !e.ill) ? int'(w[11:7]) : 0;
        return e;
    endfunction

    task automatic check_bundle();
        chk("rs1_val", dec_rs1_val, m_b.rs1);
        chk("rs2_val", dec_rs2_val, m_b.rs2);
        chk("rd", 32'(dec_rd), 32'(m_b.rd));
        chk("funct3", 32'(dec_funct3), 32'(m_b.f3));
        chk("illegal", 32'(dec_illegal), 32'(m_b.ill));
        chk("cur_pc", dec_cur_pc, m_b.cur);
        chk("nxt_pc", dec_nxt_pc, m_b.nxt);
        if (m_b.known) begin
            chk("imm", dec_imm, m_b.imm);
            chk("opType", 32'(dec_opType), 32'(m_b.typ));
            chk("aluOp", 32'(dec_aluOp), 32'(m_b.alu));
        end
    endtask

    // One clock of stimulus: check handshake before the edge, bundle after it
    task automatic cycle(input logic [31:0] w, input bit bef, input bit nxt,
                         input bit st, input bit intr);
        bit exp_rcv;
        fetch_data = w; fetch_cur_pc = pc; fetch_nxt_pc = pc + 32'd4;
        beforePipReadyToSend = bef; nextPipReadyToRcv = nxt;
        startSig = st; interrupt_start = intr;
        #2;
        exp_rcv = !m_idle && (!m_has || nxt) && !st && !intr;
        chk("rcv", 32'(curPipReadyToRcv), 32'(exp_rcv));
        chk("rs1_addr", 32'(rf_rs1_addr), 32'(w[19:15]));
        chk("rs2_addr", 32'(rf_rs2_addr), 32'(w[24:20]));
        if (st || intr) begin
            m_idle = 1'b0; m_has = 1'b0;
        end else if (exp_rcv && bef) begin
            m_has = 1'b1;
            m_b = ref_decode(w, rf_mem[w[19:15]], rf_mem[w[24:20]], pc, pc + 32'd4);
        end else if (m_has && nxt) begin
            m_has = 1'b0;
        end
        @(posedge clk); #1;
        chk("send", 32'(curPipReadyToSend), 32'(m_has));
        if (m_has) check_bundle();
        pc = pc + 32'd4;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rs1"}, dec_rs1_val, 32'd0);
        chk({tag, "_imm"}, dec_imm, 32'd0);
        chk({tag, "_rd"}, 32'(dec_rd), 32'd0);
        chk({tag, "_type"}, 32'(dec_opType), 32'd0);
        chk({tag, "_ill"}, 32'(dec_illegal), 32'd0);
        chk({tag, "_pc"}, dec_cur_pc, 32'd0);
        chk({tag, "_send"}, 32'(curPipReadyToSend), 32'd0);
        chk({tag, "_rcv"}, 32'(curPipReadyToRcv), 32'd0);
    endtask

    logic [6:0] ops [12];
    logic [31:0] w_rand;

    initial begin
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h00};
        for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
        rst = 1'b1; startSig = 0; interrupt_start = 0; fetch_data = 0;
        fetch_cur_pc = 0; fetch_nxt_pc = 0; beforePipReadyToSend = 0; nextPipReadyToRcv = 0;
        pc = 32'h0000_1000;
        m_idle = 1'b1; m_has = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // IDLE ignores fetch until started
        cycle(32'h00510093, 1, 1, 0, 0);
        cycle(32'h00510093, 1, 1, 1, 0);

        // addi x1,x2,5
        rf_mem[2] = 32'h10;
        cycle(32'h00510093, 1, 0, 0, 0);
        chk("addi_type", 32'(dec_opType), 32'd7);
        chk("addi_alu", 32'(dec_aluOp), 32'd0);
        chk("addi_rd", 32'(dec_rd), 32'd1);
        chk("addi_imm", dec_imm, 32'd5);
        chk("addi_rs1", dec_rs1_val, 32'h10);
        chk("addi_send", 32'(curPipReadyToSend), 32'd1);

        // beq x0,x0,-4 with junk in rf slot 0
        rf_mem[0] = 32'hFFFF;
        cycle(32'hFE000EE3, 1, 1, 0, 0);
        chk("beq_type", 32'(dec_opType), 32'd4);
        chk("beq_alu", 32'(dec_aluOp), 32'd1);
        chk("beq_imm", dec_imm, 32'hFFFFFFFC);
        chk("beq_rs1", dec_rs1_val, 32'd0);
        chk("beq_rs2", dec_rs2_val, 32'd0);
        chk("beq_rd", 32'(dec_rd), 32'd0);

        // lui then all-zero word back to back
        cycle(32'h123452B7, 1, 1, 0, 0);
        chk("lui_imm", dec_imm, 32'h12345000);
        chk("lui_rd", 32'(dec_rd), 32'd5);
        cycle(32'h00000000, 1, 1, 0, 0);
        chk("zero_ill", 32'(dec_illegal), 32'd1);
        chk("zero_rd", 32'(dec_rd), 32'd0);

        // Execute stalls for three cycles, then releases
        repeat (3) begin
            cycle(32'h00A00513, 1, 0, 0, 0);
            chk("stall_ill", 32'(dec_illegal), 32'd1);
            chk("stall_send", 32'(curPipReadyToSend), 32'd1);
        end
        cycle(32'h00A00513, 1, 1, 0, 0);
        chk("rel_rd", 32'(dec_rd), 32'd10);
        chk("rel_imm", dec_imm, 32'd10);

        // Interrupt discards the held bundle
        cycle(32'h00A00513, 1, 0, 0, 1);
        chk("irq_send", 32'(curPipReadyToSend), 32'd0);
        cycle(32'h00A00513, 0, 1, 0, 0);
        chk("irq_gone", 32'(curPipReadyToSend), 32'd0);

        // Asynchronous reset while holding
        cycle(32'h00510093, 1, 0, 0, 0);
        rst = 1'b1;
        #1;
        check_zero("arst");
        m_idle = 1'b1; m_has = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        cycle(32'h00510093, 1, 1, 0, 0);
        cycle(32'h00510093, 1, 1, 0, 0);
        cycle(32'h00510093, 1, 1, 1, 0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            int idx;
            if ($urandom_range(0, 15) == 0)
                for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
            idx = $urandom_range(0, 11);
            w_rand = $urandom;
            w_rand[6:0] = (idx == 11) ? 7'($urandom) : ops[idx];
            if ((w_rand[6:0] == 7'h33 || w_rand[6:0] == 7'h13) && $urandom_range(0, 3) != 0)
                w_rand[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
            cycle(w_rand, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 30) == 0, $urandom_range(0, 30) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
